// File: rtl/decode_pkg.sv
// Shared types for the decode stage: ALU op codes, opcode constants, decoded-entry payload.
// Payload widths are sized for the widest supported configuration (XLEN=64, PC_W<=64).
package decode_pkg;

  typedef enum logic [3:0] {
    ALU_AND    = 4'd0,
    ALU_SLL    = 4'd1,
    ALU_ADD    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_SUB    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_XOR    = 4'd6,
    ALU_SLTU   = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_JALR   = 4'd10,
    ALU_JAL    = 4'd11,
    ALU_STORE  = 4'd12,
    ALU_LOAD   = 4'd13,
    ALU_AUIPC  = 4'd14,
    ALU_BRANCH = 4'd15
  } alu_ctrl_e;

  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam int IMM_MAX = 64;
  localparam int PC_MAX  = 64;

  typedef struct packed {
    logic [PC_MAX-1:0]  pc;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic               rd_we;
    logic [IMM_MAX-1:0] imm;
    logic [2:0]         funct3;
    alu_ctrl_e          alu;
    logic               is_load;
    logic               is_store;
    logic               is_branch;
    logic               is_jump;
    logic               illegal;
  } dec_entry_t;

  // alt selects SUB over ADD (f3=0) and SRA over SRL (f3=5)
  function automatic alu_ctrl_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_ctrl_e a;
    case (f3)
      3'd0:    a = alt ? ALU_SUB : ALU_ADD;
      3'd1:    a = ALU_SLL;
      3'd2:    a = ALU_SLT;
      3'd3:    a = ALU_SLTU;
      3'd4:    a = ALU_XOR;
      3'd5:    a = alt ? ALU_SRA : ALU_SRL;
      3'd6:    a = ALU_OR;
      default: a = ALU_AND;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Combinational RV32I/RV64I decode of one instruction word into a dec_entry_t.
// Latency 0; no handshake, the enclosing stage owns all flow control.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic [31:0]   inst,
  input  logic [PC_W-1:0] pc,
  output dec_entry_t    entry
);

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [IMM_MAX-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic legal;

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign f7     = inst[31:25];

  // Immediates are built at 64 bits; truncation to XLEN keeps the sign extension correct.
  assign imm_i  = IMM_MAX'($signed(inst[31:20]));
  assign imm_s  = IMM_MAX'($signed({inst[31:25], inst[11:7]}));
  assign imm_b  = IMM_MAX'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u  = IMM_MAX'($signed({inst[31:12], 12'h000}));
  assign imm_j  = IMM_MAX'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
  assign imm_sh = (XLEN == 32) ? IMM_MAX'(inst[24:20]) : IMM_MAX'(inst[25:20]);

  always_comb begin
    entry        = '0;
    entry.pc     = PC_MAX'(pc);
    entry.funct3 = f3;
    entry.alu    = ALU_BRANCH;
    legal        = 1'b1;
    case (opcode)
      OPC_OP: begin
        entry.rs1 = rs1;
        entry.rs2 = rs2;
        entry.rd  = rd;
        entry.alu = alu_from_f3(f3, f7[5]);
        if (!((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)))))
          legal = 1'b0;
      end
      OPC_OP_IMM: begin
        entry.rs1 = rs1;
        entry.rd  = rd;
        if ((f3 == 3'd1) || (f3 == 3'd5)) begin
          entry.imm = imm_sh;
          entry.alu = alu_from_f3(f3, (f3 == 3'd5) && inst[30]);
          if ((XLEN == 32) && inst[25])
            legal = 1'b0;
        end else begin
          entry.imm = imm_i;
          entry.alu = alu_from_f3(f3, 1'b0);
        end
      end
      OPC_LOAD: begin
        entry.rs1     = rs1;
        entry.rd      = rd;
        entry.imm     = imm_i;
        entry.alu     = ALU_LOAD;
        entry.is_load = 1'b1;
      end
      OPC_STORE: begin
        entry.rs1      = rs1;
        entry.rs2      = rs2;
        entry.imm      = imm_s;
        entry.alu      = ALU_STORE;
        entry.is_store = 1'b1;
      end
      OPC_BRANCH: begin
        entry.rs1       = rs1;
        entry.rs2       = rs2;
        entry.imm       = imm_b;
        entry.alu       = ALU_BRANCH;
        entry.is_branch = 1'b1;
      end
      OPC_LUI: begin
        entry.rd  = rd;
        entry.imm = imm_u;
        entry.alu = ALU_ADD;
      end
      OPC_AUIPC: begin
        entry.rd  = rd;
        entry.imm = imm_u;
        entry.alu = ALU_AUIPC;
      end
      OPC_JALR: begin
        entry.rs1     = rs1;
        entry.rd      = rd;
        entry.imm     = imm_i;
        entry.alu     = ALU_JALR;
        entry.is_jump = 1'b1;
      end
      OPC_JAL: begin
        entry.rd      = rd;
        entry.imm     = imm_j;
        entry.alu     = ALU_JAL;
        entry.is_jump = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      entry         = '0;
      entry.pc      = PC_MAX'(pc);
      entry.funct3  = f3;
      entry.alu     = ALU_BRANCH;
      entry.illegal = 1'b1;
    end else begin
      entry.rd_we = (entry.rd != 5'd0) && !entry.is_store && !entry.is_branch;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: main register plus one skid register, valid/ready on both sides.
// Latency 1 cycle; in_ready (registered) drops only while the skid register is occupied.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_funct3,
  output logic [3:0]      out_alu_ctrl,
  output logic            out_is_load,
  output logic            out_is_store,
  output logic            out_is_branch,
  output logic            out_is_jump,
  output logic            out_illegal
);

  dec_entry_t dec_new, main_q, skid_q;
  logic main_vld, skid_vld, rdy_q;
  logic in_xfer;
  logic unused_bits;

  decode_comb #(.XLEN(XLEN), .PC_W(PC_W)) u_comb (
    .inst  (in_inst),
    .pc    (in_pc),
    .entry (dec_new)
  );

  assign in_xfer = in_valid && rdy_q;

  // in_xfer never coincides with skid_vld because rdy_q tracks !skid_vld.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b1;
    end else if (!main_vld || out_ready) begin
      if (skid_vld) begin
        main_q   <= skid_q;
        main_vld <= 1'b1;
        skid_vld <= 1'b0;
        rdy_q    <= 1'b1;
      end else if (in_xfer) begin
        main_q   <= dec_new;
        main_vld <= 1'b1;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (in_xfer) begin
      skid_q   <= dec_new;
      skid_vld <= 1'b1;
      rdy_q    <= 1'b0;
    end
  end

  assign in_ready      = rdy_q;
  assign out_valid     = main_vld;
  assign out_pc        = main_q.pc[PC_W-1:0];
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_rd        = main_q.rd;
  assign out_rd_we     = main_q.rd_we;
  assign out_imm       = main_q.imm[XLEN-1:0];
  assign out_funct3    = main_q.funct3;
  assign out_alu_ctrl  = main_q.alu;
  assign out_is_load   = main_q.is_load;
  assign out_is_store  = main_q.is_store;
  assign out_is_branch = main_q.is_branch;
  assign out_is_jump   = main_q.is_jump;
  assign out_illegal   = main_q.illegal;

  // Upper payload bits exist only for the widest configuration.
  assign unused_bits = ^{main_q.pc, main_q.imm};

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors, expected entries queued on accept.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rd_we, out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal;
  logic [2:0]  out_funct3;
  logic [3:0]  out_alu_ctrl;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_imm(out_imm), .out_funct3(out_funct3), .out_alu_ctrl(out_alu_ctrl),
    .out_is_load(out_is_load), .out_is_store(out_is_store), .out_is_branch(out_is_branch),
    .out_is_jump(out_is_jump), .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic [3:0]  alu;
    logic [4:0]  flg;   // {load, store, branch, jump, illegal}
  } exp_t;

  localparam logic [4:0] F_LD = 5'b10000, F_ST = 5'b01000, F_BR = 5'b00100,
                         F_JP = 5'b00010, F_IL = 5'b00001, F_NO = 5'b00000;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic we, input logic [31:0] imm,
                              input logic [2:0] f3, input logic [3:0] alu, input logic [4:0] flg);
    exp_t e;
    e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.we = we;
    e.imm = imm; e.f3 = f3; e.alu = alu; e.flg = flg;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  // Monitor: every output transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t g, e;
    if (!rst && out_valid && out_ready) begin
      g.pc = out_pc; g.rs1 = out_rs1; g.rs2 = out_rs2; g.rd = out_rd; g.we = out_rd_we;
      g.imm = out_imm; g.f3 = out_funct3; g.alu = out_alu_ctrl;
      g.flg = {out_is_load, out_is_store, out_is_branch, out_is_jump, out_illegal};
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_out: pc=0x%0h emitted with nothing expected", out_pc);
      end else begin
        e = sb.pop_front();
        if (g !== e) begin
          fails++;
          $display("FAIL entry pc=0x%0h: got rs1=%0d rs2=%0d rd=%0d we=%0b imm=0x%0h f3=%0d alu=%0d flg=%b, want pc=0x%0h rs1=%0d rs2=%0d rd=%0d we=%0b imm=0x%0h f3=%0d alu=%0d flg=%b",
                   g.pc, g.rs1, g.rs2, g.rd, g.we, g.imm, g.f3, g.alu, g.flg,
                   e.pc, e.rs1, e.rs2, e.rd, e.we, e.imm, e.f3, e.alu, e.flg);
        end
      end
    end
  end

  // Presents one instruction until accepted (bounded); queues the expectation if it should emerge.
  task automatic send(input logic [31:0] inst, input logic [31:0] pc, input exp_t e, input bit push);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++; fails++;
      $display("FAIL accept_timeout: pc=0x%0h not accepted within %0d cycles", pc, n);
    end else if (push) begin
      sb.push_back(e);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_fields", {out_pc, out_rd, out_alu_ctrl, out_illegal}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // addi x1,x0,-1 with one-cycle latency
    send(32'hFFF00093, 32'h100, mk(32'h100, 0, 0, 1, 1, 32'hFFFFFFFF, 0, 2, F_NO), 1);
    @(negedge clk);
    chk("addi_latency", out_valid, 1);
    @(posedge clk); #1;

    send(32'h402081B3, 32'h104, mk(32'h104, 1, 2, 3, 1, 32'h0, 0, 4, F_NO), 1);           // sub
    send(32'h4032D293, 32'h108, mk(32'h108, 5, 0, 5, 1, 32'h3, 5, 9, F_NO), 1);           // srai
    send(32'h0020A423, 32'h10C, mk(32'h10C, 1, 2, 0, 0, 32'h8, 2, 12, F_ST), 1);          // sw
    send(32'hFE000EE3, 32'h110, mk(32'h110, 0, 0, 0, 0, 32'hFFFFFFFC, 0, 15, F_BR), 1);   // beq -4
    send(32'h00000000, 32'h114, mk(32'h114, 0, 0, 0, 0, 32'h0, 0, 15, F_IL), 1);          // all-zero
    send(32'h800003B7, 32'h118, mk(32'h118, 0, 0, 7, 1, 32'h80000000, 0, 2, F_NO), 1);    // lui
    send(32'h00001217, 32'h11C, mk(32'h11C, 0, 0, 4, 1, 32'h1000, 1, 14, F_NO), 1);       // auipc
    send(32'hFF812303, 32'h120, mk(32'h120, 2, 0, 6, 1, 32'hFFFFFFF8, 2, 13, F_LD), 1);   // lw
    send(32'h00C5B533, 32'h124, mk(32'h124, 11, 12, 10, 1, 32'h0, 3, 7, F_NO), 1);        // sltu
    send(32'h01F09093, 32'h128, mk(32'h128, 1, 0, 1, 1, 32'd31, 1, 1, F_NO), 1);          // slli 31
    send(32'h021080B3, 32'h12C, mk(32'h12C, 0, 0, 0, 0, 32'h0, 0, 15, F_IL), 1);          // funct7=1
    send(32'h0200D093, 32'h130, mk(32'h130, 0, 0, 0, 0, 32'h0, 5, 15, F_IL), 1);          // shamt[5] on RV32

    // Backpressure: second entry parks in skid, third is held off until the stall clears.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h003100B3, 32'h200, mk(32'h200, 2, 3, 1, 1, 32'h0, 0, 2, F_NO), 1);           // add
    send(32'h0062C233, 32'h204, mk(32'h204, 5, 6, 4, 1, 32'h0, 4, 6, F_NO), 1);           // xor
    @(negedge clk);
    chk("skid_full_in_ready", in_ready, 0);
    chk("stall_hold_pc", out_pc, 32'h200);
    fork
      send(32'h009473B3, 32'h208, mk(32'h208, 8, 9, 7, 1, 32'h0, 7, 0, F_NO), 1);         // and
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("stall_still_hold_pc", out_pc, 32'h200);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Flush with skid full and an input presented in the same cycle.
    out_ready = 1'b0;
    send(32'h003100B3, 32'h300, mk(32'h300, 2, 3, 1, 1, 32'h0, 0, 2, F_NO), 0);
    send(32'h0062C233, 32'h304, mk(32'h304, 5, 6, 4, 1, 32'h0, 4, 6, F_NO), 0);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h308;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);

    // An input actually accepted in the flush cycle is dropped too.
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h402081B3; in_pc = 32'h30C;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_accept_drop", out_valid, 0);
    @(posedge clk); #1;

    // Asynchronous reset mid-stall clears everything before the next edge.
    out_ready = 1'b0;
    send(32'h003100B3, 32'h400, mk(32'h400, 2, 3, 1, 1, 32'h0, 0, 2, F_NO), 0);
    send(32'h0062C233, 32'h404, mk(32'h404, 5, 6, 4, 1, 32'h0, 4, 6, F_NO), 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_zero", {out_pc, out_rs1, out_rs2, out_rd, out_imm}, 0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

    send(32'h008000EF, 32'h500, mk(32'h500, 0, 0, 1, 1, 32'h8, 0, 11, F_JP), 1);          // jal +8
    send(32'h00008067, 32'h504, mk(32'h504, 1, 0, 0, 0, 32'h0, 0, 10, F_JP), 1);          // jalr x0

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
